// File: rtl/jseq_ctrl.sv
// Run-length sequencer driving a WIDTH-stage Johnson ring with one-hot phase decode.
// Optional build macro JSEQ_SELFCORRECT_EN: clears illegal ring patterns and pulses o_err.
module jseq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               in_start,
  input  logic [CNT_W-1:0]   in_steps,
  input  logic               in_dir,
  input  logic               in_hold,
  input  logic               in_stop,
  input  logic               in_load,
  input  logic [WIDTH-1:0]   in_seed,
  output logic [WIDTH-1:0]   o_q,
  output logic [2*WIDTH-1:0] o_phase,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   ring_q;
  logic [CNT_W-1:0]   rem_q;
  logic               dir_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [WIDTH-1:0]   ring_fwd;
  logic [WIDTH-1:0]   ring_rev;
  logic               fix;

  assign ring_fwd = {~ring_q[0], ring_q[WIDTH-1:1]};
  assign ring_rev = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};

`ifdef JSEQ_SELFCORRECT_EN
  logic [WIDTH-2:0] trans;
  logic             ring_legal;
  logic             load_now;

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_trans
    assign trans[gi] = ring_q[gi] ^ ring_q[gi+1];
  end

  assign ring_legal = $onehot0(trans);
  assign load_now   = (state_q == S_IDLE) && !in_start && in_load;
  // Clearing replaces a RUN step, so it is suppressed only by a load.
  assign fix        = !ring_legal && !load_now;
`else
  assign fix = 1'b0;
`endif

  // Pattern of the k-th forward state from all-zeros.
  function automatic logic [WIDTH-1:0] phase_pat(input int k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) p[i] = (i >= WIDTH - k);
      else            p[i] = (i < 2 * WIDTH - k);
    end
    return p;
  endfunction

  for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_phase
    assign o_phase[gi] = (ring_q == phase_pat(gi));
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      ring_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= fix;
      if (fix) ring_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (in_start) begin
            if (in_steps != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              rem_q   <= in_steps;
              dir_q   <= in_dir;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (in_load) begin
            ring_q <= in_seed;
          end
        end
        S_RUN: begin
          if (in_stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (!in_hold && !fix) begin
            ring_q <= dir_q ? ring_rev : ring_fwd;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_q    = ring_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_jseq_ctrl.sv
// Randomized and directed bench for jseq_ctrl against a phase-index reference model.
module tb_jseq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] steps = '0;
  logic          dir   = 1'b0;
  logic          hold  = 1'b0;
  logic          stop  = 1'b0;
  logic          load  = 1'b0;
  logic [W-1:0]  seed  = '0;
  logic [W-1:0]  q;
  logic [2*W-1:0] phase;
  logic          busy, done, err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_q;
  bit           m_run, m_done, m_err, m_dir;
  int           m_rem;

  jseq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_steps(steps),
    .in_dir(dir), .in_hold(hold), .in_stop(stop), .in_load(load), .in_seed(seed),
    .o_q(q), .o_phase(phase), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th state walking forward from zero: k ones entering from the MSB, then zeros.
  function automatic logic [W-1:0] pat(input int k);
    int v;
    if (k <= W) v = ((1 << k) - 1) << (W - k);
    else        v = (1 << (2 * W - k)) - 1;
    return W'(v);
  endfunction

  function automatic int phase_of(input logic [W-1:0] v);
    for (int k = 0; k < 2 * W; k++)
      if (pat(k) == v) return k;
    return -1;
  endfunction

  function automatic logic [31:0] exp_phase(input logic [W-1:0] v);
    int k;
    k = phase_of(v);
    if (k < 0) return 32'd0;
    return 32'(1) << k;
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] v, input bit rev);
    int k;
    k = phase_of(v);
    if (k >= 0) return rev ? pat((k + 2 * W - 1) % (2 * W)) : pat((k + 1) % (2 * W));
    return rev ? {v[W-2:0], ~v[W-1]} : {~v[0], v[W-1:1]};
  endfunction

  task automatic model_reset();
    m_q = '0; m_run = 0; m_done = 0; m_err = 0; m_dir = 0; m_rem = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] nq;
    bit fix;
    nq = m_q;
`ifdef JSEQ_SELFCORRECT_EN
    fix = (phase_of(m_q) < 0);
`else
    fix = 1'b0;
`endif
    m_err = 1'b0;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_run) begin
      if (stop) m_run = 1'b0;
      else if (!hold && !fix) begin
        nq = advance(m_q, m_dir);
        m_rem--;
        if (m_rem == 0) begin m_run = 1'b0; m_done = 1'b1; end
      end
    end else if (start) begin
      if (steps != '0) begin m_run = 1'b1; m_rem = int'(steps); m_dir = dir; end
      else m_done = 1'b1;
    end else if (load) begin
      nq = seed;
      fix = 1'b0;
    end
    if (fix) begin nq = '0; m_err = 1'b1; end
    m_q = nq;
  endtask

  task automatic compare_all();
    chk("q", 32'(q), 32'(m_q));
    chk("phase", 32'(phase), exp_phase(m_q));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Called at a negedge: drive inputs, clock once, update model, compare.
  task automatic cycle(input bit s, input int n, input bit d, input bit h,
                       input bit sp, input bit l, input int sd);
    start = s; steps = CW'(n); dir = d; hold = h; stop = sp; load = l; seed = W'(sd);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [W-1:0] t1_seq [5];
  int dcount;

  initial begin
    model_reset();
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_phase", 32'(phase), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // forward run of 3
    t1_seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1110};
    cycle(1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_q", 32'(q), 32'(t1_seq[i]));
      chk("t1_done", 32'(done), 32'(i == 3));
      chk("t1_busy", 32'(busy), 32'(i < 3));
      idle(1);
    end

    // reverse full lap of 8 from 0000
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(1, 8, 1, 0, 0, 0, 0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dcount++;
        chk("t2_phase_end", 32'(phase), 32'd1);
      end
      idle(1);
    end
    chk("t2_done_cnt", 32'(dcount), 32'd1);

    // hold then stop
    cycle(1, 5, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("t3_frozen", 32'(q), 32'(4'b1100));
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("t3_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t3_nodone", 32'(done), 32'd0);
    end
    chk("t3_q", 32'(q), 32'(4'b1100));

    // zero-step start
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_q", 32'(q), 32'(4'b1100));
    idle(1);

    // illegal seed
    cycle(0, 0, 0, 0, 0, 1, 5);
    idle(1);
`ifdef JSEQ_SELFCORRECT_EN
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_q", 32'(q), 32'd0);
`else
    chk("t5_q", 32'(q), 32'(4'b0101));
    chk("t5_phase", 32'(phase), 32'd0);
`endif
    cycle(0, 0, 0, 0, 0, 1, 0);

    // async reset mid-run
    cycle(1, 6, 0, 0, 0, 0, 0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_q", 32'(q), 32'd0);
    chk("t6_phase", 32'(phase), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // start during DONE is ignored
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t6_done1", 32'(done), 32'd1);
    cycle(1, 4, 0, 0, 0, 0, 0);
    chk("t6_ignored", 32'(busy), 32'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      int n;
      n = $urandom_range(0, 9);
      if ($urandom_range(0, 59) == 0) n = 255;
      cycle($urandom_range(0, 3) == 0, n, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
